clk_rst_ctrl: RTL

CLK_RST_CTRL -- requirements
Module: clk_rst_ctrl

---
 rtl/clk_rst_ctrl_pkg.sv | 17 +
 rtl/sync_2ff.sv | 15 +
 rtl/clk_rst_ctrl.sv | 96 +++++++++
 3 files changed

// File: rtl/clk_rst_ctrl_pkg.sv
// clk_rst_ctrl_pkg: sequencer state encoding and counter sizing helper
package clk_rst_ctrl_pkg;

   typedef enum logic [2:0] {
      PLL_RST,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } state_t;

   // bits needed for a counter that runs 0..n-1
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchroniser for a single asynchronous bit
module sync_2ff (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) {q, meta} <= 2'b00;
      else {q, meta} <= {meta, d};

endmodule

// File: rtl/clk_rst_ctrl.sv
// clk_rst_ctrl: PLL reset sequencing, lock qualification and staggered domain reset release
module clk_rst_ctrl
   import clk_rst_ctrl_pkg::*;
#(
   parameter int N_DOMAINS       = 2,
   parameter int PLL_RST_CYC     = 16,
   parameter int LOCK_STABLE_CYC = 1024,
   parameter int RELEASE_GAP_CYC = 8,
   parameter int TIMEOUT_CYC     = 65536
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 pll_lock_i,
   input  logic                 force_relock_i,
   output logic                 pll_rst_o,
   output logic [N_DOMAINS-1:0] dom_rst_n_o,
   output logic                 ready_o,
   output logic                 timeout_o,
   output logic [7:0]           relock_cnt_o
);

   localparam int REL_LEN = (N_DOMAINS - 1) * RELEASE_GAP_CYC + 1;
   localparam int PW = cnt_w(PLL_RST_CYC);
   localparam int SW = cnt_w(LOCK_STABLE_CYC);
   localparam int WW = cnt_w(TIMEOUT_CYC);
   localparam int RW = cnt_w(REL_LEN);

   state_t state, state_n;
   logic lock, loss, tmo;
   logic [PW-1:0] pll_cnt;
   logic [SW-1:0] stab_cnt;
   logic [WW-1:0] wait_cnt;
   logic [RW-1:0] rel_cnt, rel_cnt_n;
   logic [N_DOMAINS-1:0] dom_n;

   sync_2ff u_lock_sync (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d       (pll_lock_i),
      .q       (lock)
   );

   always_comb begin
      state_n = state;
      loss = 1'b0;
      tmo = 1'b0;
      case (state)
         PLL_RST:   if (pll_cnt == PW'(PLL_RST_CYC - 1)) state_n = WAIT_LOCK;
         WAIT_LOCK: if (lock) state_n = STABLE;
                    else if (wait_cnt == WW'(TIMEOUT_CYC - 1)) begin
                       tmo = 1'b1;
                       state_n = PLL_RST;
                    end
         STABLE:    if (!lock) state_n = WAIT_LOCK;
                    else if (stab_cnt == SW'(LOCK_STABLE_CYC - 1)) state_n = RELEASE;
         RELEASE:   if (rel_cnt == RW'(REL_LEN - 1)) state_n = RUN;
         default:   ;
      endcase
      if ((state == RELEASE || state == RUN) && !lock) begin
         loss = 1'b1;
         state_n = PLL_RST;
      end
      // a forced relock overrides everything but never counts as a loss
      if (state != PLL_RST && force_relock_i) state_n = PLL_RST;
      rel_cnt_n = (state == RELEASE && state_n == RELEASE) ? rel_cnt + RW'(1) : '0;
      for (int k = 0; k < N_DOMAINS; k++)
         dom_n[k] = state_n == RUN || (state_n == RELEASE && rel_cnt_n >= RW'(k * RELEASE_GAP_CYC));
   end

   // outputs are registered from the next state so they line up with it
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state        <= PLL_RST;
         pll_cnt      <= '0;
         stab_cnt     <= '0;
         wait_cnt     <= '0;
         rel_cnt      <= '0;
         pll_rst_o    <= 1'b1;
         dom_rst_n_o  <= '0;
         ready_o      <= 1'b0;
         timeout_o    <= 1'b0;
         relock_cnt_o <= '0;
      end else begin
         state       <= state_n;
         pll_cnt     <= (state == PLL_RST && state_n == PLL_RST) ? pll_cnt + PW'(1) : '0;
         wait_cnt    <= (state == WAIT_LOCK && state_n == WAIT_LOCK) ? wait_cnt + WW'(1) : '0;
         stab_cnt    <= (state == STABLE && state_n == STABLE) ? stab_cnt + SW'(1) : '0;
         rel_cnt     <= rel_cnt_n;
         pll_rst_o   <= state_n == PLL_RST;
         dom_rst_n_o <= dom_n;
         ready_o     <= state_n == RUN;
         if (tmo) timeout_o <= 1'b1;
         if (loss && relock_cnt_o != 8'hff) relock_cnt_o <= relock_cnt_o + 8'd1;
      end

endmodule
